fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch front-end that consumes the PC produced by the PC generator and turns it into in-order instruction memory requests. It returns `{pc, instr}` pairs to decode through a valid/ready buffer. It drives `fetch_ready_o` back to the PC generator so the PC advances only when a request is accepted or a redirect must be loaded. On `flush_i` (exception or mispredict) it empties its buffer and silently discards every response still in flight from before the flush.

## Interface
- `DEPTH`, default 4: instruction buffer entries and maximum in-flight plus buffered requests. Must be a power of two, ≥2.
- `clk_i` in, 1: clock, rising edge.
- `rst_i` in, 1: reset, synchronous, active-high.
- `pc_i` in, XLEN: current PC from the PC generator.
- `fetch_ready_o` out, 1: PC generator may load its next PC this cycle.
- `flush_i` in, 1: redirect (exception or mispredict). The PC generator loads the redirect target this cycle.
- `imem_req_valid_o` out, 1: fetch request valid.
- `imem_req_ready_i` in, 1: memory accepts the request.
- `imem_req_addr_o` out, XLEN: request address, equal to `pc_i`.
- `imem_resp_valid_i` in, 1: response valid. Responses arrive in order, at least 1 cycle after acceptance, and are always accepted.
- `imem_resp_data_i` in, ILEN: instruction word.
- `instr_valid_o` out, 1: instruction available to decode.
- `instr_ready_i` in, 1: decode accepts.
- `instr_o` out, ILEN: instruction.
- `instr_pc_o` out, XLEN: PC of `instr_o`.

## Operation
- **Counters**, each `$clog2(DEPTH+1)` bits:
  - `out_cnt`: accepted requests whose response has not arrived yet.
  - `drop_cnt`: stale in-flight responses that must be discarded.
  - `buf_cnt`: buffer occupancy.
- **Credit rule:** `credit = (out_cnt + drop_cnt + buf_cnt) < DEPTH`. The sum is evaluated at width+1 bits, so it cannot overflow.
- **Request issue:**
  - `imem_req_valid_o = !rst_i && !flush_i && credit`.
  - The request is accepted when `imem_req_valid_o && imem_req_ready_i`.
  - On acceptance: `pc_i` is pushed into the PC queue (depth DEPTH) and `out_cnt` increments.
- **Request withdrawal:** the memory tolerates `imem_req_valid_o` being withdrawn only in a flush cycle.
- **PC handshake:** `fetch_ready_o = !rst_i && (accept || flush_i)`. The PC is consumed exactly once per accepted request, and a redirect is never blocked.
- **Response, `drop_cnt > 0`:** the response is discarded and `drop_cnt` decrements.
- **Response, `drop_cnt == 0`:** the response pops the head of the PC queue, writes `{pc, data}` into the buffer, and `out_cnt` decrements.
- **Output:** the buffer head drives `instr_*_o`. It pops on `instr_valid_o && instr_ready_i`.
- **Flush (cycle F):**
  - Buffer and PC queue are cleared.
  - `drop_cnt` ← `drop_cnt + out_cnt − (resp_valid && drop_cnt==0 ? 1 : 0)`, and a response arriving in cycle F with `drop_cnt > 0` also consumes one unit.
  - `out_cnt` ← 0.
  - Any response in cycle F is discarded.
  - A downstream handshake in cycle F completes, but decode is flushed by the same `flush_i`.
- **Simultaneous events in one cycle:** request accept, response arrival and output pop all apply. Counter updates are summed and never lost.

## Timing
- **Reset values:**
  - `imem_req_valid_o`, `fetch_ready_o`, `instr_valid_o` = 0.
  - `instr_o`, `instr_pc_o` = 0.
  - All counters, queue and buffer pointers = 0.
- **Reset mid-operation:** outstanding responses are not tracked afterwards. The memory is reset together with the fetch stage.
- **Latency:** request accepted in cycle N, response in cycle N+L (L ≥ 1), `instr_valid_o` in cycle N+L+1 (registered buffer).
- **Throughput:** one request per cycle while credit holds and the memory is ready.
- **Full condition:** no credit, so `imem_req_valid_o` = 0 and `fetch_ready_o` = 0, and the PC holds.
- **Empty condition:** `instr_valid_o` = 0.
- **Pointer wrap-around:** modulo DEPTH.
- **First fetch after flush:** the first post-flush request can issue in cycle F+1 with the new `pc_i`.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the buffer is empty, `drop_cnt == 0` and `flush_i` = 0, a response is presented combinationally on `instr_*_o` in cycle N+L.
  - If decode accepts it in that cycle, the response is not written to the buffer.
- `FETCH_BYPASS_EN` undefined: every response goes through the buffer, and output latency is always +1 cycle.

## Structure
- `XLEN`, `ILEN` and `BOOT_PC` come from `mmm_pkg`.
- Add `fetch_entry_t` (`pc` XLEN, `instr` ILEN) to `mmm_pkg`.
- One sub-module: `fetch_fifo`, a parametric sync FIFO with push, pop, clear, full, empty and count. It is instantiated twice: once as the PC queue and once as the instruction buffer.

## Test plan
- **Streaming:** DEPTH=4, memory always ready, L=1, `pc_i` = 0x100, 0x104, … → one `fetch_ready_o` per cycle. `instr_pc_o` = 0x100 at cycle 2 without bypass, cycle 1 with bypass.
- **Back-pressure:** hold `instr_ready_i` = 0 → after 4 accepts, `imem_req_valid_o` and `fetch_ready_o` drop. Release it → 4 entries drain in order, then requests resume.
- **Flush with in-flight requests:** 3 requests outstanding with L=4, assert `flush_i` with new `pc_i` = 0x800 → the 3 stale responses are dropped. The first `instr_pc_o` after the flush is 0x800.
- **Flush and response in the same cycle:** that response is discarded and `drop_cnt` ends at `out_cnt` − 1.
- **Memory stall:** `imem_req_ready_i` = 0 for 5 cycles → `fetch_ready_o` = 0 throughout and `pc_i` is unchanged.
- **Reset mid-stream:** assert `rst_i` for 1 cycle → all outputs are 0 the next cycle and counters are zero.

Source files
------------

// File: rtl/mmm_pkg.sv
// Shared core parameters and the fetch-to-decode entry type.
package mmm_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] BOOT_PC = 32'h0000_0100;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parametric synchronous FIFO with clear; DEPTH must be a power of two >= 2.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// In-order instruction fetch front-end with credit-limited requests and flush drop tracking.
// Optional: define FETCH_BYPASS_EN to present a response on the outputs in its arrival cycle.
module fetch_stage
  import mmm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            fetch_ready_o,
  input  logic            flush_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_resp_valid_i,
  input  logic [ILEN-1:0] imem_resp_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   buf_cnt, pcq_cnt;
  logic [SW-1:0]   occupancy;
  logic            credit, accept, resp_keep, resp_drop;
  logic            buf_push, buf_pop, buf_full, buf_empty;
  logic            pcq_full, pcq_empty;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t    buf_in, buf_head, out_entry;
  logic            unused_status;

  assign occupancy        = SW'(out_cnt_q) + SW'(drop_cnt_q) + SW'(buf_cnt);
  assign credit           = occupancy < SW'(DEPTH);
  assign imem_req_valid_o = !rst_i && !flush_i && credit;
  assign imem_req_addr_o  = pc_i;
  assign accept           = imem_req_valid_o && imem_req_ready_i;
  assign fetch_ready_o    = !rst_i && (accept || flush_i);

  assign resp_drop = imem_resp_valid_i && (drop_cnt_q != '0);
  assign resp_keep = imem_resp_valid_i && (drop_cnt_q == '0) && !flush_i;
  assign buf_in    = '{pc: pcq_head, instr: imem_resp_data_i};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass        = !rst_i && buf_empty && resp_keep;
  assign instr_valid_o = !rst_i && (!buf_empty || bypass);
  assign buf_push      = resp_keep && !(bypass && instr_ready_i);
  assign out_entry     = buf_empty ? buf_in : buf_head;
`else
  assign instr_valid_o = !rst_i && !buf_empty;
  assign buf_push      = resp_keep;
  assign out_entry     = buf_head;
`endif

  assign buf_pop    = instr_valid_o && instr_ready_i;
  assign instr_o    = instr_valid_o ? out_entry.instr : '0;
  assign instr_pc_o = instr_valid_o ? out_entry.pc    : '0;

  always_comb begin
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      // A response in the flush cycle retires either an outstanding or a drop unit;
      // both are folded into drop_cnt here, so the combined total falls by one.
      out_cnt_d  = '0;
      drop_cnt_d = drop_cnt_q + out_cnt_q - CW'(imem_resp_valid_i);
    end else begin
      out_cnt_d  = out_cnt_q + CW'(accept) - CW'(resp_keep);
      drop_cnt_d = drop_cnt_q - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (accept),
    .data_i  (pc_i),
    .pop_i   (resp_keep),
    .data_o  (pcq_head),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_cnt)
  );

  fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (flush_i),
    .push_i  (buf_push),
    .data_i  (buf_in),
    .pop_i   (buf_pop),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_cnt)
  );

  assign unused_status = ^{pcq_full, pcq_empty, pcq_cnt, buf_full};

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: PC generator + in-order memory model, decoupled output monitor.
module tb_fetch_stage;
  import mmm_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int unsigned FIRST = 1;
`else
  localparam int unsigned FIRST = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_i, flush_i, imem_req_ready_i, imem_resp_valid_i, instr_ready_i;
  logic [XLEN-1:0] pc_i, imem_req_addr_o, instr_pc_o;
  logic [ILEN-1:0] imem_resp_data_i, instr_o;
  logic            fetch_ready_o, imem_req_valid_o, instr_valid_o;

  always #5 clk = ~clk;

  fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .pc_i              (pc_i),
    .fetch_ready_o     (fetch_ready_o),
    .flush_i           (flush_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .instr_valid_o     (instr_valid_o),
    .instr_ready_i     (instr_ready_i),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o)
  );

  typedef struct {
    int unsigned     due;
    logic [XLEN-1:0] addr;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t exp_q[$];
  int unsigned  cyc, lat;
  logic [XLEN-1:0] flush_pc, pc_nxt;
  int           n_checks, n_errors;
  logic            s_rv, s_fr, s_iv;
  logic [XLEN-1:0] s_pc;
  logic [ILEN-1:0] s_in;

  function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return ILEN'(~a);
  endfunction

  function automatic void check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endfunction

  // One clock cycle: sample at negedge, drive next-cycle inputs 1 time unit after posedge.
  task automatic step();
    @(negedge clk);
    s_rv = imem_req_valid_o; s_fr = fetch_ready_o; s_iv = instr_valid_o;
    s_pc = instr_pc_o;       s_in = instr_o;
    pc_nxt = pc_i;
    if (rst_i) begin
      mem_q.delete();
    end else begin
      if (flush_i) check_bit("no_req_in_flush", imem_req_valid_o, 1'b0);
      else if (imem_req_valid_o && imem_req_ready_i) begin
        mem_q.push_back('{due: cyc + lat, addr: imem_req_addr_o});
        exp_q.push_back('{pc: imem_req_addr_o, instr: mem_word(imem_req_addr_o)});
      end
      if (fetch_ready_o) pc_nxt = flush_i ? flush_pc : pc_i + XLEN'(4);
    end
    @(posedge clk);
    cyc++;
    #1;
    pc_i = pc_nxt;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = '0;
    end
  endtask

  task automatic do_reset(input logic [XLEN-1:0] start_pc);
    rst_i = 1'b1;
    pc_i  = start_pc;
    step();
    rst_i = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [XLEN-1:0] exp_pc, input logic [ILEN-1:0] exp_in);
    int unsigned n = 0;
    do begin
      step();
      n++;
    end while (!s_iv && n < 20);
    check_bit({name, "_seen"}, s_iv, 1'b1);
    if (s_iv) begin
      check({name, "_pc"}, s_pc, exp_pc);
      check({name, "_instr"}, s_in, exp_in);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; imem_req_ready_i = 1'b1; instr_ready_i = 1'b1;
    imem_resp_valid_i = 1'b0; imem_resp_data_i = '0; pc_i = BOOT_PC;
    lat = 1; cyc = 0; flush_pc = '0; n_checks = 0; n_errors = 0;

    fork
      forever begin
        fetch_entry_t e;
        @(negedge clk);
        if (rst_i) exp_q.delete();
        else begin
          if (instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_errors++;
              $display("FAIL sb_unexpected: got pc 0x%0h, required no output", instr_pc_o);
            end else begin
              e = exp_q.pop_front();
              check("sb_pc", instr_pc_o, e.pc);
              check("sb_instr", instr_o, e.instr);
            end
          end
          if (flush_i) exp_q.delete();
        end
      end
    join_none

    // Reset values
    pc_i = 32'h100;
    step(); step();
    check_bit("rst_req_valid", s_rv, 1'b0);
    check_bit("rst_fetch_ready", s_fr, 1'b0);
    check_bit("rst_instr_valid", s_iv, 1'b0);
    check("rst_instr_pc", s_pc, '0);
    check("rst_instr", s_in, '0);
    rst_i = 1'b0;

    // Streaming, L=1
    for (int unsigned i = 0; i < 8; i++) begin
      step();
      check_bit("stream_fetch_ready", s_fr, 1'b1);
      check_bit("stream_latency", s_iv, i >= FIRST);
      if (i == FIRST) check("stream_first_pc", s_pc, 32'h100);
    end
    check("stream_pc_advance", pc_i, 32'h120);

    // Reset mid-stream
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_bit("midrst_req_valid", s_rv, 1'b0);
    check_bit("midrst_fetch_ready", s_fr, 1'b0);
    check_bit("midrst_instr_valid", s_iv, 1'b0);
    pc_i = 32'h200;
    instr_ready_i = 1'b0;
    step();
    check_bit("postrst_instr_valid", s_iv, 1'b0);
    check("postrst_instr_pc", s_pc, '0);
    check("postrst_instr", s_in, '0);

    // Back-pressure: cycle 0 was the step above
    check_bit("bp_fetch_ready_0", s_fr, 1'b1);
    for (int unsigned i = 1; i < 8; i++) begin
      step();
      check_bit("bp_fetch_ready", s_fr, i < 4);
      check_bit("bp_req_valid", s_rv, i < 4);
    end
    check("bp_pc_held", pc_i, 32'h210);
    instr_ready_i = 1'b1;
    step();
    check_bit("bp_release_no_credit_yet", s_fr, 1'b0);
    step();
    check_bit("bp_resume", s_fr, 1'b1);
    for (int unsigned i = 0; i < 10; i++) step();

    // Memory stall
    imem_req_ready_i = 1'b0;
    do_reset(32'h500);
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      check_bit("stall_fetch_ready", s_fr, 1'b0);
      check_bit("stall_req_valid", s_rv, 1'b1);
      check("stall_pc_held", pc_i, 32'h500);
    end
    imem_req_ready_i = 1'b1;
    step();
    check_bit("stall_release", s_fr, 1'b1);
    wait_valid("stall_first", 32'h500, 32'hFFFF_FAFF);

    // Flush with three requests in flight, L=4
    lat = 4;
    do_reset(32'h300);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check_bit("inflight_accept", s_fr, 1'b1);
    end
    flush_i = 1'b1; flush_pc = 32'h800;
    step();
    flush_i = 1'b0;
    check_bit("flush_req_valid", s_rv, 1'b0);
    check_bit("flush_fetch_ready", s_fr, 1'b1);
    check("flush_pc_loaded", pc_i, 32'h800);
    wait_valid("flush_first", 32'h800, 32'hFFFF_F7FF);

    // Flush coinciding with a response, L=2
    lat = 2;
    do_reset(32'h400);
    step(); step();
    flush_i = 1'b1; flush_pc = 32'h900;
    step();
    flush_i = 1'b0;
    wait_valid("flush_resp", 32'h900, 32'hFFFF_F6FF);

    // Drain: no new requests, everything expected must come out
    imem_req_ready_i = 1'b0;
    for (int unsigned i = 0; i < 12; i++) step();
    check("sb_drained", XLEN'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
